// File: rtl/mcs_bridge_gen2.sv
// MicroBlaze MCS IO bus to FPro slave bridge: decodes a 16 MB window into
// N_REGION slave regions, with programmable read latency and sticky miss reporting.
module mcs_bridge_gen2 #(
  parameter logic [31:0] BRG_BASE = 32'hc000_0000,
  parameter int          N_REGION = 2,
  parameter int          RD_LAT   = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    io_addr_strobe,
  input  logic                    io_read_strobe,
  input  logic                    io_write_strobe,
  input  logic [31:0]             io_address,
  input  logic [3:0]              io_byte_enable,
  input  logic [31:0]             io_write_data,
  output logic [31:0]             io_read_data,
  output logic                    io_ready,
  output logic [N_REGION-1:0]     fp_cs,
  output logic                    fp_wr,
  output logic                    fp_rd,
  output logic [20:0]             fp_addr,
  output logic [31:0]             fp_wr_data,
  output logic [3:0]              fp_byte_en,
  input  logic [32*N_REGION-1:0]  fp_rd_data,
  output logic                    bus_err,
  output logic [31:0]             err_addr,
  input  logic                    err_clr
);

  localparam int RBITS = $clog2(N_REGION);
  localparam logic [N_REGION-1:0] CS_ONE = 1;

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RESP, MISS} state_t;

  state_t           state;
  logic [2:0]       rd_cnt;
  logic [RBITS-1:0] region;

  logic             req;
  logic             hit;
  logic [RBITS-1:0] req_region;
  logic [31:0]      rd_slice;

  // Both strobes together is a protocol error: accepted, but never a hit.
  assign req        = io_addr_strobe & (io_read_strobe | io_write_strobe);
  assign hit        = (io_read_strobe ^ io_write_strobe) &&
                      (io_address[31:24] == BRG_BASE[31:24]);
  assign req_region = io_address[23 -: RBITS];
  assign rd_slice   = fp_rd_data[32*region +: 32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rd_cnt       <= '0;
      region       <= '0;
      io_ready     <= 1'b0;
      io_read_data <= '0;
      fp_cs        <= '0;
      fp_wr        <= 1'b0;
      fp_rd        <= 1'b0;
      fp_addr      <= '0;
      fp_wr_data   <= '0;
      fp_byte_en   <= '0;
      bus_err      <= 1'b0;
      err_addr     <= '0;
    end else begin
      // A miss accepted in the same cycle overrides this clear below.
      if (err_clr) bus_err <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              fp_addr    <= 21'(io_address[23-RBITS:2]);
              fp_wr_data <= io_write_data;
              fp_byte_en <= io_byte_enable;
              region     <= req_region;
              fp_cs      <= CS_ONE << req_region;
              if (io_write_strobe) begin
                fp_wr <= 1'b1;
                state <= WR;
              end else begin
                fp_rd <= 1'b1;
                state <= RD;
              end
            end else begin
              bus_err <= 1'b1;
              if (!bus_err || err_clr) err_addr <= io_address;
              if (io_read_strobe) io_read_data <= '0;
              io_ready <= 1'b1;
              state    <= MISS;
            end
          end
        end

        WR: begin
          fp_wr    <= 1'b0;
          fp_cs    <= '0;
          io_ready <= 1'b1;
          state    <= RESP;
        end

        RD: begin
          fp_rd <= 1'b0;
          if (RD_LAT == 0) begin
            io_read_data <= rd_slice;
            fp_cs        <= '0;
            io_ready     <= 1'b1;
            state        <= RESP;
          end else begin
            rd_cnt <= 3'(RD_LAT - 1);
            state  <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (rd_cnt == 3'd0) begin
            io_read_data <= rd_slice;
            fp_cs        <= '0;
            io_ready     <= 1'b1;
            state        <= RESP;
          end else begin
            rd_cnt <= rd_cnt - 3'd1;
          end
        end

        RESP, MISS: begin
          io_ready <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcs_bridge_gen2.sv
// Bench for mcs_bridge_gen2: two instances (2 regions / zero latency and
// 4 regions / three-cycle latency) driven by shared requests and a reference model.
module tb_mcs_bridge_gen2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         as, rs, ws, err_clr;
  logic [31:0]  addr, wdata;
  logic [3:0]   be;
  logic [63:0]  rdd2;
  logic [127:0] rdd4;

  logic [31:0] rdat2, wd2, ea2, rdat4, wd4, ea4;
  logic        rdy2, wr2, rd2, berr2, rdy4, wr4, rd4, berr4;
  logic [1:0]  cs2;
  logic [3:0]  cs4, be2, be4;
  logic [20:0] fa2, fa4;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_rdata [2];
  logic [20:0] m_fa [2];
  logic [31:0] m_wd, m_eaddr;
  logic [3:0]  m_be;
  logic        m_err;
  logic        ov_en;
  logic [31:0] ov_val;

  always #5 clk = ~clk;

  mcs_bridge_gen2 #(.BRG_BASE(32'hc000_0000), .N_REGION(2), .RD_LAT(0)) u2 (
    .clk(clk), .reset_n(reset_n), .io_addr_strobe(as), .io_read_strobe(rs),
    .io_write_strobe(ws), .io_address(addr), .io_byte_enable(be),
    .io_write_data(wdata), .io_read_data(rdat2), .io_ready(rdy2), .fp_cs(cs2),
    .fp_wr(wr2), .fp_rd(rd2), .fp_addr(fa2), .fp_wr_data(wd2), .fp_byte_en(be2),
    .fp_rd_data(rdd2), .bus_err(berr2), .err_addr(ea2), .err_clr(err_clr));

  mcs_bridge_gen2 #(.BRG_BASE(32'hc000_0000), .N_REGION(4), .RD_LAT(3)) u4 (
    .clk(clk), .reset_n(reset_n), .io_addr_strobe(as), .io_read_strobe(rs),
    .io_write_strobe(ws), .io_address(addr), .io_byte_enable(be),
    .io_write_data(wdata), .io_read_data(rdat4), .io_ready(rdy4), .fp_cs(cs4),
    .fp_wr(wr4), .fp_rd(rd4), .fp_addr(fa4), .fp_wr_data(wd4), .fp_byte_en(be4),
    .fp_rd_data(rdd4), .bus_err(berr4), .err_addr(ea4), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata[0] = '0; m_rdata[1] = '0; m_fa[0] = '0; m_fa[1] = '0;
    m_wd = '0; m_be = '0; m_err = 1'b0; m_eaddr = '0;
  endtask

  task automatic chk_all_zero();
    chk("u2.rst.ready", rdy2, 0);  chk("u4.rst.ready", rdy4, 0);
    chk("u2.rst.cs", cs2, 0);      chk("u4.rst.cs", cs4, 0);
    chk("u2.rst.wrrd", {wr2, rd2}, 0); chk("u4.rst.wrrd", {wr4, rd4}, 0);
    chk("u2.rst.addr", fa2, 0);    chk("u4.rst.addr", fa4, 0);
    chk("u2.rst.wdata", wd2, 0);   chk("u4.rst.wdata", wd4, 0);
    chk("u2.rst.be", be2, 0);      chk("u4.rst.be", be4, 0);
    chk("u2.rst.rdata", rdat2, 0); chk("u4.rst.rdata", rdat4, 0);
    chk("u2.rst.err", berr2, 0);   chk("u4.rst.err", berr4, 0);
    chk("u2.rst.eaddr", ea2, 0);   chk("u4.rst.eaddr", ea4, 0);
  endtask

  // One MCS request followed by a 7-cycle observation window on both instances.
  task automatic txn(input logic [31:0] a, input logic r, input logic w,
                     input logic [3:0] b, input logic [31:0] d, input logic clr,
                     input logic inject, input logic rel);
    int lat [2];
    int rk [2];
    int cs_last [2];
    int nrdy [2];
    int idx [2];
    logic hit;
    logic [3:0] oh [2];
    lat[0] = 0; lat[1] = 3; nrdy[0] = 0; nrdy[1] = 0;
    hit = (a[31:24] == 8'hc0) && (r ^ w);
    idx[0] = int'(a[23]);
    idx[1] = int'(a[23:22]);
    rdd2 = {$urandom, $urandom};
    rdd4 = {$urandom, $urandom, $urandom, $urandom};
    if (ov_en) begin
      rdd2[32*idx[0] +: 32] = ov_val;
      rdd4[32*idx[1] +: 32] = ov_val;
    end
    for (int i = 0; i < 2; i++) begin
      oh[i] = 4'(1 << idx[i]);
      rk[i] = !hit ? 1 : (w ? 2 : 2 + lat[i]);
      cs_last[i] = !hit ? 0 : (w ? 1 : 1 + lat[i]);
    end

    if (hit) begin
      m_fa[0] = a[22:2];
      m_fa[1] = {1'b0, a[21:2]};
      m_wd = d; m_be = b;
      if (r) begin
        m_rdata[0] = rdd2[32*idx[0] +: 32];
        m_rdata[1] = rdd4[32*idx[1] +: 32];
      end
      if (clr) m_err = 1'b0;
    end else begin
      if (!m_err || clr) m_eaddr = a;
      m_err = 1'b1;
      if (r) begin m_rdata[0] = '0; m_rdata[1] = '0; end
    end

    @(negedge clk);
    addr = a; as = 1'b1; rs = r; ws = w; be = b; wdata = d; err_clr = clr;
    if (rel) reset_n = 1'b1;

    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      as = 1'b0; rs = 1'b0; ws = 1'b0; err_clr = 1'b0;
      if (inject && k == 2) begin
        as = 1'b1; ws = 1'b1; addr = 32'hc000_0040;
      end
      if (rdy2) nrdy[0]++;
      if (rdy4) nrdy[1]++;
      chk("u2.ready", rdy2, 32'(k == rk[0]));
      chk("u4.ready", rdy4, 32'(k == rk[1]));
      chk("u2.fp_wr", wr2, 32'(hit && w && k == 1));
      chk("u4.fp_wr", wr4, 32'(hit && w && k == 1));
      chk("u2.fp_rd", rd2, 32'(hit && r && k == 1));
      chk("u4.fp_rd", rd4, 32'(hit && r && k == 1));
      chk("u2.fp_cs", cs2, (k <= cs_last[0]) ? 32'(oh[0][1:0]) : 0);
      chk("u4.fp_cs", cs4, (k <= cs_last[1]) ? 32'(oh[1]) : 0);
    end
    as = 1'b0; ws = 1'b0;

    chk("u2.ready_count", nrdy[0], 1);
    chk("u4.ready_count", nrdy[1], 1);
    chk("u2.rdata", rdat2, m_rdata[0]);
    chk("u4.rdata", rdat4, m_rdata[1]);
    chk("u2.fp_addr", fa2, m_fa[0]);
    chk("u4.fp_addr", fa4, m_fa[1]);
    chk("u2.fp_wr_data", wd2, m_wd);
    chk("u4.fp_wr_data", wd4, m_wd);
    chk("u2.fp_byte_en", be2, m_be);
    chk("u4.fp_byte_en", be4, m_be);
    chk("u2.bus_err", berr2, m_err);
    chk("u4.bus_err", berr4, m_err);
    chk("u2.err_addr", ea2, m_eaddr);
    chk("u4.err_addr", ea4, m_eaddr);
  endtask

  initial begin
    logic [31:0] a;
    logic        r, w, bo;
    reset_n = 1'b0; as = 1'b0; rs = 1'b0; ws = 1'b0; err_clr = 1'b0;
    addr = '0; wdata = '0; be = '0; rdd2 = '0; rdd4 = '0;
    ov_en = 1'b0; ov_val = '0;
    model_reset();

    repeat (3) @(negedge clk);
    chk_all_zero();

    // Write hit to region 0, released from reset in the same cycle as the request.
    txn(32'hc000_0010, 1'b0, 1'b1, 4'hf, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    chk("u2.fp_addr_word4", fa2, 32'h4);

    // Read hit into the top region with a known slice value.
    ov_en = 1'b1; ov_val = 32'hdead_beef;
    txn(32'hc0c0_0008, 1'b1, 1'b0, 4'hf, 32'h0, 1'b0, 1'b0, 1'b0);
    ov_en = 1'b0;
    chk("u4.rdata_deadbeef", rdat4, 32'hdead_beef);

    // Read misses: first one latches err_addr, second leaves it alone.
    txn(32'h8000_0004, 1'b1, 1'b0, 4'hf, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("u4.miss_rdata", rdat4, 32'h0);
    txn(32'h8000_0008, 1'b1, 1'b0, 4'hf, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("u4.second_miss_eaddr", ea4, 32'h8000_0004);

    // Clear coinciding with a new miss.
    txn(32'h9000_0000, 1'b0, 1'b1, 4'h3, 32'h55aa_55aa, 1'b1, 1'b0, 1'b0);
    chk("u2.clr_miss_eaddr", ea2, 32'h9000_0000);

    // Plain clear.
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_err = 1'b0;
    chk("u2.err_cleared", berr2, 0);
    chk("u4.err_cleared", berr4, 0);
    chk("u4.eaddr_kept", ea4, 32'h9000_0000);

    // Strobe during the read wait is ignored; both strobes takes the miss path.
    txn(32'hc040_0020, 1'b1, 1'b0, 4'hf, 32'h0, 1'b0, 1'b1, 1'b0);
    txn(32'hc000_0030, 1'b1, 1'b1, 4'hf, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset during the read wait aborts the read.
    @(negedge clk);
    addr = 32'hc080_0010; as = 1'b1; rs = 1'b1;
    @(negedge clk);
    as = 1'b0; rs = 1'b0;
    chk("u4.abort_fp_rd", rd4, 1);
    repeat (2) @(negedge clk);
    chk("u4.abort_cs_held", cs4, 4'b0100);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero();
    repeat (4) begin
      @(negedge clk);
      chk("u4.no_ready_in_reset", rdy4, 0);
    end
    txn(32'hc0c0_0100, 1'b0, 1'b1, 4'ha, 32'hcafe_f00d, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[31:24] = 8'hc0;
      else if (a[31:24] == 8'hc0) a[31:24] = 8'h40;
      r  = 1'($urandom_range(1));
      bo = ($urandom_range(9) == 0);
      w  = bo ? 1'b1 : ~r;
      if (bo) r = 1'b1;
      txn(a, r, w, 4'($urandom), $urandom, ($urandom_range(5) == 0), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
